// File: rtl/screen_draw_ctrl.sv
// Drives one full-frame image memory per request and realigns its x/y with the registered ROM colour.
// Latency: memory x/y at cycle k reaches vga_* at k+2; req_ready only in IDLE, requests while busy are dropped.
module screen_draw_ctrl #(
  parameter int NUM_SCREENS = 4,
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  input  logic [2:0]               req_screen,
  output logic                     req_ready,
  output logic [NUM_SCREENS-1:0]   mem_en,
  input  logic [9*NUM_SCREENS-1:0] src_x,
  input  logic [9*NUM_SCREENS-1:0] src_y,
  input  logic [6*NUM_SCREENS-1:0] src_colour,
  input  logic [NUM_SCREENS-1:0]   src_done,
  output logic [8:0]               vga_x,
  output logic [7:0]               vga_y,
  output logic [5:0]               vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     sync_err
);

  localparam logic [16:0] TOTAL = 17'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        live;
  logic [2:0]  sel;
  logic [16:0] pix_cnt;
  logic        in_range;
  logic        accept;

  logic [8:0]  x_mux;
  logic [8:0]  y_mux;
  logic [5:0]  c_mux;
  logic        done_sel;
  logic        y_msb_unused;

  logic [8:0]  x1;
  logic [7:0]  y1;
  logic        v1;

  // live holds req_ready low through the reset cycle itself
  assign in_range  = {1'b0, req_screen} < 4'(NUM_SCREENS);
  assign req_ready = live && (state == IDLE);
  assign accept    = req_ready && req_valid && in_range;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    mem_en     = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = DRAW;
      end
      DRAW: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_SCREENS; i++) begin
          mem_en[i] = (sel == 3'(i));
        end
        // The memory needs this final enabled cycle to self-clear and raise done
        if (pix_cnt == TOTAL) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      live     <= 1'b0;
      sel      <= '0;
      pix_cnt  <= '0;
      sync_err <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        sel      <= req_screen;
        pix_cnt  <= '0;
        sync_err <= 1'b0;
      end else if (state == DRAW) begin
        pix_cnt <= pix_cnt + 17'd1;
        if (done_sel) sync_err <= 1'b1;
      end else if (state == FLUSH) begin
        if (!done_sel) sync_err <= 1'b1;
      end
    end
  end

  always_comb begin
    x_mux    = '0;
    y_mux    = '0;
    c_mux    = '0;
    done_sel = 1'b0;
    for (int i = 0; i < NUM_SCREENS; i++) begin
      if (sel == 3'(i)) begin
        x_mux    = src_x[9*i +: 9];
        y_mux    = src_y[9*i +: 9];
        c_mux    = src_colour[6*i +: 6];
        done_sel = src_done[i];
      end
    end
  end

  // y never exceeds HEIGHT-1 while plotting, so the top bit is dropped
  assign y_msb_unused = y_mux[8];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x1         <= '0;
      y1         <= '0;
      v1         <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      x1         <= x_mux;
      y1         <= y_mux[7:0];
      v1         <= (state == DRAW) && (pix_cnt < TOTAL);
      vga_x      <= v1 ? x1 : 9'd0;
      vga_y      <= v1 ? y1 : 8'd0;
      vga_colour <= v1 ? c_mux : 6'd0;
      vga_plot   <= v1;
    end
  end

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Bench for screen_draw_ctrl: small 4x2 frames against a pixel scoreboard plus one full 320x240 frame.
module tb_screen_draw_ctrl;

  localparam int NS   = 4;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam int BW   = 320;
  localparam int BH   = 240;
  localparam int BPIX = BW * BH;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic            req_valid;
  logic [2:0]      req_screen;
  logic            req_ready;
  logic [NS-1:0]   mem_en;
  logic [9*NS-1:0] src_x;
  logic [9*NS-1:0] src_y;
  logic [6*NS-1:0] src_colour;
  logic [NS-1:0]   src_done;
  logic [8:0]      vga_x;
  logic [7:0]      vga_y;
  logic [5:0]      vga_colour;
  logic            vga_plot;
  logic            busy;
  logic            frame_done;
  logic            sync_err;

  logic       big_resetn;
  logic       big_valid;
  logic       big_ready;
  logic [0:0] big_en;
  logic [8:0] big_sx;
  logic [8:0] big_sy;
  logic [5:0] big_sc;
  logic [0:0] big_sd;
  logic [8:0] big_x;
  logic [7:0] big_y;
  logic [5:0] big_col;
  logic       big_plot;
  logic       big_busy;
  logic       big_fd;
  logic       big_se;

  int n_checks = 0;
  int n_fail   = 0;
  pix_t exp_q[$];

  logic [63:0] m_en_any, m_en_sel, m_plot, m_fd, m_busy, m_ready, m_se;

  screen_draw_ctrl #(.NUM_SCREENS(NS), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_screen(req_screen),
    .req_ready(req_ready), .mem_en(mem_en), .src_x(src_x), .src_y(src_y),
    .src_colour(src_colour), .src_done(src_done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  screen_draw_ctrl #(.NUM_SCREENS(1), .WIDTH(BW), .HEIGHT(BH)) big (
    .clk(clk), .resetn(big_resetn), .req_valid(big_valid), .req_screen(3'd0),
    .req_ready(big_ready), .mem_en(big_en), .src_x(big_sx), .src_y(big_sy),
    .src_colour(big_sc), .src_done(big_sd), .vga_x(big_x), .vga_y(big_y),
    .vga_colour(big_col), .vga_plot(big_plot), .busy(big_busy),
    .frame_done(big_fd), .sync_err(big_se)
  );

  function automatic logic [5:0] rom(input int s, input int a);
    return 6'((a * 7 + s * 11 + 3) % 64);
  endfunction

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural image memories: x/y from a counter, colour is ROM q registered one cycle
  int         mcnt [NS];
  logic [5:0] mq   [NS];
  logic [NS-1:0] mdone;
  bit         suppress;

  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (!resetn) begin
        mcnt[s]  <= 0;
        mq[s]    <= '0;
        mdone[s] <= 1'b0;
      end else begin
        mq[s]    <= rom(s, mcnt[s]);
        mdone[s] <= 1'b0;
        if (mem_en[s]) begin
          if (mcnt[s] == NPIX) begin
            mcnt[s]  <= 0;
            mdone[s] <= !suppress;
          end else begin
            mcnt[s] <= mcnt[s] + 1;
          end
        end
      end
    end
  end

  always_comb begin
    src_x      = '0;
    src_y      = '0;
    src_colour = '0;
    for (int s = 0; s < NS; s++) begin
      src_x[9*s +: 9]      = 9'(mcnt[s] % W);
      src_y[9*s +: 9]      = 9'(mcnt[s] / W);
      src_colour[6*s +: 6] = mq[s];
    end
  end
  assign src_done = mdone;

  int         bcnt;
  logic [5:0] bq;
  logic       bdone;
  always @(posedge clk) begin
    if (!big_resetn) begin
      bcnt  <= 0;
      bq    <= '0;
      bdone <= 1'b0;
    end else begin
      bq    <= rom(0, bcnt);
      bdone <= 1'b0;
      if (big_en[0]) begin
        if (bcnt == BPIX) begin
          bcnt  <= 0;
          bdone <= 1'b1;
        end else begin
          bcnt <= bcnt + 1;
        end
      end
    end
  end
  assign big_sx = 9'(bcnt % BW);
  assign big_sy = 9'(bcnt / BW);
  assign big_sc = bq;
  assign big_sd = bdone;

  // Scoreboard sink: every plotted pixel must match the oldest pending expectation
  always @(negedge clk) begin
    pix_t e;
    if (vga_plot) begin
      if (exp_q.size() == 0) begin
        check("extra_pixel", 64'(vga_plot), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("pix_x", 64'(vga_x), 64'(e.x));
        check("pix_y", 64'(vga_y), 64'(e.y));
        check("pix_colour", 64'(vga_colour), 64'(e.c));
      end
    end
  end

  task automatic push_frame(input int scr, input int n);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.x = 9'(i % W);
      p.y = 8'(i / W);
      p.c = rom(scr, i);
      exp_q.push_back(p);
    end
  endtask

  task automatic start(input int scr, input bit hold);
    @(posedge clk);
    #1 req_valid = 1'b1;
    req_screen = 3'(scr);
    @(posedge clk);
    #1 if (!hold) req_valid = 1'b0;
  endtask

  task automatic window(input int scr, input int n, input int rv_off);
    logic [NS-1:0] oh;
    oh = NS'(1) << scr;
    m_en_any = '0; m_en_sel = '0; m_plot = '0; m_fd = '0;
    m_busy = '0; m_ready = '0; m_se = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      m_en_any[c] = |mem_en;
      m_en_sel[c] = (|mem_en) && (mem_en == oh);
      m_plot[c]   = vga_plot;
      m_fd[c]     = frame_done;
      m_busy[c]   = busy;
      m_ready[c]  = req_ready;
      m_se[c]     = sync_err;
      if (c == rv_off) req_valid = 1'b0;
    end
  endtask

  task automatic check_single(input string t);
    check({t, "_en_any"}, m_en_any, rng(0, NPIX));
    check({t, "_en_sel"}, m_en_sel, rng(0, NPIX));
    check({t, "_plot"}, m_plot, rng(2, NPIX + 1));
    check({t, "_frame_done"}, m_fd, rng(NPIX + 2, NPIX + 2));
    check({t, "_busy"}, m_busy, rng(0, NPIX + 2));
    check({t, "_ready"}, m_ready, rng(NPIX + 3, NPIX + 3));
    check({t, "_pending"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic small_seq();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_plot", 64'(vga_plot), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_sync_err", 64'(sync_err), 64'(0));
    check("rst_colour", 64'(vga_colour), 64'(0));
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("ready_at_release", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("ready_after_release", 64'(req_ready), 64'(1));

    push_frame(2, NPIX);
    start(2, 1'b0);
    window(2, 12, -1);
    check_single("single");
    check("single_sync_err", m_se, 64'(0));

    push_frame(1, NPIX);
    push_frame(1, NPIX);
    start(1, 1'b1);
    window(1, 24, 23);
    check("b2b_en_any", m_en_any, rng(0, 8) | rng(12, 20));
    check("b2b_en_sel", m_en_sel, rng(0, 8) | rng(12, 20));
    check("b2b_plot", m_plot, rng(2, 9) | rng(14, 21));
    check("b2b_frame_done", m_fd, rng(10, 10) | rng(22, 22));
    check("b2b_busy", m_busy, rng(0, 10) | rng(12, 22));
    check("b2b_ready", m_ready, rng(11, 11) | rng(23, 23));
    check("b2b_pending", 64'(exp_q.size()), 64'(0));

    push_frame(3, NPIX);
    start(3, 1'b1);
    req_screen = 3'd0;
    window(3, 12, 8);
    check_single("busy_req");

    @(posedge clk);
    #1 req_valid = 1'b1;
    req_screen = 3'd5;
    window(5, 6, 4);
    check("invalid_en", m_en_any, 64'(0));
    check("invalid_busy", m_busy, 64'(0));
    check("invalid_ready", m_ready, rng(0, 5));
    check("invalid_plot", m_plot, 64'(0));

    suppress = 1'b1;
    push_frame(0, NPIX);
    start(0, 1'b0);
    window(0, 12, -1);
    check_single("nodone");
    check("nodone_sync_err", m_se, rng(10, 11));
    suppress = 1'b0;
    push_frame(1, NPIX);
    start(1, 1'b0);
    window(1, 12, -1);
    check_single("clear");
    check("clear_sync_err", m_se, 64'(0));

    push_frame(2, 4);
    start(2, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("midrst_mem_en", 64'(mem_en), 64'(0));
    check("midrst_plot", 64'(vga_plot), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_colour", 64'(vga_colour), 64'(0));
    check("midrst_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("midrst_ready_next", 64'(req_ready), 64'(1));
    check("midrst_pending", 64'(exp_q.size()), 64'(0));
    push_frame(2, NPIX);
    start(2, 1'b0);
    window(2, 12, -1);
    check_single("after_rst");
  endtask

  task automatic big_seq();
    int cnt, first, last, fdc, fdn;
    logic [8:0] lx;
    logic [7:0] ly;
    logic [5:0] lc;
    cnt = 0; first = -1; last = -1; fdc = -1; fdn = 0;
    lx = '0; ly = '0; lc = '0;
    repeat (3) @(posedge clk);
    #1 big_resetn = 1'b1;
    @(posedge clk);
    #1 big_valid = 1'b1;
    @(posedge clk);
    #1 big_valid = 1'b0;
    for (int c = 0; c < BPIX + 10; c++) begin
      @(negedge clk);
      if (big_plot) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
        lx = big_x;
        ly = big_y;
        lc = big_col;
      end
      if (big_fd) begin
        fdn++;
        fdc = c;
      end
    end
    check("big_plot_count", 64'(cnt), 64'(BPIX));
    check("big_first_plot", 64'(first), 64'(2));
    check("big_last_plot", 64'(last), 64'(BPIX + 1));
    check("big_last_x", 64'(lx), 64'(BW - 1));
    check("big_last_y", 64'(ly), 64'(BH - 1));
    check("big_last_colour", 64'(lc), 64'(rom(0, BPIX - 1)));
    check("big_frame_done_cycle", 64'(fdc), 64'(BPIX + 2));
    check("big_frame_done_count", 64'(fdn), 64'(1));
    check("big_sync_err", 64'(big_se), 64'(0));
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_screen = 3'd0;
    suppress   = 1'b0;
    big_resetn = 1'b0;
    big_valid  = 1'b0;
    fork
      small_seq();
      big_seq();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at %0t, limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/screen_draw_ctrl.md
Name: screen_draw_ctrl

Overview:
- Sits between the game FSM and the VGA adapter.
- On request, enables exactly one full-frame image memory (win, lose, title, etc.) for one frame.
- Multiplexes that memory's x/y/colour stream and realigns x/y with the registered-ROM colour, which lags by one cycle.
- Produces a clean per-pixel plot strobe for the adapter, plus a frame-done pulse and a sync-error flag.

Parameters:
- NUM_SCREENS, 4, number of attached image memories (1..8).
- WIDTH, 320, pixels per row; must match the memories.
- HEIGHT, 240, rows per frame; must match the memories.

Ports:
- clk  in  1  system clock; all logic is posedge.
- resetn  in  1  synchronous, active-low reset; shared with the image memories.
- req_valid  in  1  draw request strobe from the game FSM.
- req_screen  in  3  index of the memory to draw; only indices < NUM_SCREENS are valid.
- req_ready  out  1  high only in IDLE.
- mem_en  out  NUM_SCREENS  one-hot writeEn to the image memories.
- src_x  in  9*NUM_SCREENS  packed x from each memory; slice i is [9i+8:9i].
- src_y  in  9*NUM_SCREENS  packed y from each memory.
- src_colour  in  6*NUM_SCREENS  packed colour from each memory; ROM q, lags its x/y by 1 cycle.
- src_done  in  NUM_SCREENS  done_plotting pulse from each memory.
- vga_x  out  9  pixel x to the adapter.
- vga_y  out  8  pixel y to the adapter.
- vga_colour  out  6  pixel colour to the adapter.
- vga_plot  out  1  adapter writeEn; one pixel per high cycle.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_done  out  1  one-cycle pulse when the last pixel has been presented.
- sync_err  out  1  sticky; set when src_done is missing or early; cleared by reset or by the next accepted request.

Behaviour:
- Reset: all outputs 0 (req_ready=0 during reset), FSM in IDLE, counters 0, sel 0.
- req_ready becomes 1 in the first cycle after resetn rises.
- FSM states: IDLE, DRAW, FLUSH, DONE.
- IDLE:
  - req_valid=1 with req_screen<NUM_SCREENS: latch sel=req_screen, clear pix_cnt and sync_err, go to DRAW.
  - Out-of-range index: request ignored, stay in IDLE, no flag set.
- DRAW:
  - mem_en[sel]=1, all other mem_en bits 0, for exactly WIDTH*HEIGHT+1 cycles. The memory needs the extra cycle to self-clear and raise done.
  - pix_cnt (17 bits) increments every DRAW cycle.
  - Leave for FLUSH in the cycle where pix_cnt==WIDTH*HEIGHT.
  - mem_en must not stay high past that cycle; otherwise the memory restarts its count.
- Alignment pipe (runs every cycle, all states):
  - Stage 1 registers src_x[sel], src_y[sel] and v1 = (state==DRAW && pix_cnt<WIDTH*HEIGHT).
  - Stage 2 registers vga_x <= x1, vga_y <= y1[7:0], vga_colour <= src_colour[sel], vga_plot <= v1.
  - Net latency: memory x/y at cycle k -> vga_* at cycle k+2, paired with ROM[k].
- Timing, with cycle 0 = first DRAW cycle:
  - vga_plot is high for cycles 2..WIDTH*HEIGHT+1 inclusive, with no gaps.
  - vga_colour is 0 and vga_plot is 0 when idle.
- FLUSH (1 cycle, cycle WIDTH*HEIGHT+1):
  - mem_en=0.
  - src_done[sel] must be 1 this cycle, else set sync_err.
  - src_done[sel]=1 during DRAW also sets sync_err.
  - src_done from a non-selected memory is ignored.
- DONE (1 cycle, cycle WIDTH*HEIGHT+2): frame_done=1, vga_plot=0, then return to IDLE.
- busy=1 in DRAW, FLUSH and DONE; req_valid is ignored while busy (no queueing).
- Reset mid-frame: next cycle all outputs 0 and state IDLE. Memories reset on the same resetn, so the next request starts from pixel (0,0).
- Width rules:
  - vga_y is truncated to 8 bits; y never exceeds HEIGHT-1 when vga_plot=1.
  - pix_cnt compare uses the WIDTH*HEIGHT constant, evaluated at elaboration.

Test Plan:
- Use behavioural memory models with WIDTH=4, HEIGHT=2. Model ROM q = address-indexed colour, registered one cycle.
- Single draw: request screen 2 -> mem_en=3'b100 for exactly 9 cycles. vga_plot high for cycles 2..9 with (x,y,colour) = (0,0,C0)..(3,1,C7) in order. frame_done at cycle 10. sync_err=0.
- Back-to-back: req_valid held high through two frames -> second frame starts the cycle after IDLE re-entry. Memory model restarts at pixel 0; no extra en cycle occurs.
- Busy/invalid: req_valid while busy -> ignored. req_screen=5 with NUM_SCREENS=4 in IDLE -> stays IDLE, mem_en=0, req_ready=1.
- Done mismatch: model suppresses done -> sync_err=1 after FLUSH, frame_done still pulses. Next valid request clears sync_err.
- Reset at cycle 5 of DRAW -> next cycle mem_en=0, vga_plot=0, busy=0. A fresh request yields a full 8-pixel frame from (0,0).
- Full-size run at 320x240 -> exactly 76800 vga_plot cycles. Last pixel (319,239) at cycle 76801; frame_done at cycle 76802.
